deserializer: RTL and testbench
===============================

DESERIALIZER -- requirements
Module: deserializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the parallel word width in bits.
REQ-002 The block SHALL have parameter COUNT_WIDTH, default 3, giving the bit counter width, with 2^COUNT_WIDTH >= WIDTH.
REQ-003 The block SHALL have port clk, input, 1 bit, the clock.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset; clock clk.
REQ-005 The block SHALL have port ser_data, input, 1 bit, the serial bit value, sampled when ser_strobe is high.
REQ-006 The block SHALL have port ser_strobe, input, 1 bit, level-valid; each clock cycle it is high delivers one bit.
REQ-007 The block SHALL have port ser_ready, output, 1 bit; high means a bit offered this cycle is accepted.
REQ-008 The block SHALL have port frame_reset, input, 1 bit, a synchronous resync that discards the partial word.
REQ-009 The block SHALL have port par_data, output, WIDTH bits, the completed word in the holding register.
REQ-010 The block SHALL have port par_ready, input, 1 bit; high means downstream can accept a word (the !full of a one-level buffer).
REQ-011 The block SHALL have port par_strobe, output, 1 bit, a registered one-cycle pulse meaning par_data is valid for capture.
REQ-012 The block SHALL have port overrun, output, 1 bit, a sticky flag set when a bit was dropped.
REQ-013 The block SHALL have port is_empty, output, 1 bit: high when there is no partial bit and no pending word.

Function
REQ-014 The block SHALL assemble bits MSB-first: the first accepted bit SHALL end in par_data[WIDTH-1] and the WIDTH-th in par_data[0].
REQ-015 On each accepted bit (ser_strobe && ser_ready), the shifter SHALL become {shifter[WIDTH-2:0], ser_data} and bit_count SHALL increment.
REQ-016 On the accepted bit that takes bit_count from WIDTH-1 to 0, the assembled word SHALL load into the holding register (par_data) and internal pending SHALL be set at the same edge.
REQ-017 bit_count SHALL wrap from WIDTH-1 to 0; it SHALL never reach WIDTH.
REQ-018 ser_ready SHALL be combinational: low only when pending=1 and bit_count=WIDTH-1, and high otherwise.
REQ-019 A bit offered while ser_ready is low SHALL be discarded, with shifter and bit_count unchanged, and overrun SHALL be set to 1 at that edge.
REQ-020 At an edge where pending=1, par_ready=1 and par_strobe=0, the block SHALL set par_strobe to 1 and clear pending; at all other edges par_strobe SHALL be 0.
REQ-021 par_ready SHALL be ignored during any cycle in which par_strobe is high, giving a minimum strobe spacing of 2 cycles (1 high, at least 1 low) so that downstream edge detection and its full flag settle.
REQ-022 Latency: last bit accepted in cycle k -> pending from cycle k+1 -> earliest par_strobe high in cycle k+2.
REQ-023 par_data SHALL remain stable from the edge that loads it through the end of its par_strobe cycle; it may reload at the edge that ends the strobe cycle.
REQ-024 If the last bit of a new word completes at the same edge that issues par_strobe, pending SHALL remain 1 for the new word and the new word SHALL load.
REQ-025 When frame_reset is high at an edge, bit_count, shifter and overrun SHALL clear, any ser_strobe in that cycle SHALL be discarded, and pending and par_data SHALL be preserved.
REQ-026 Priority SHALL be: reset > frame_reset > normal operation; par_strobe issue SHALL proceed regardless of frame_reset.
REQ-027 is_empty SHALL be registered and equal (bit_count==0 && !pending) after each edge.

Reset
REQ-028 While reset is high, par_data=0, par_strobe=0, overrun=0, is_empty=1, bit_count=0, shifter=0 and pending=0, hence ser_ready=1.
REQ-029 Reset asserted mid-word or with a word pending SHALL discard all data; the first word after release SHALL be assembled from fresh bits only.

Verification
REQ-030 ser_strobe continuous with bits 1,0,1,0,0,1,0,1 and par_ready=1 -> par_data=0xA5, a single par_strobe pulse 2 cycles after the last bit, then is_empty=1.
REQ-031 0x3C then 0xC3 streamed back-to-back with par_ready=1 -> two pulses 8 cycles apart, ser_ready never low, and overrun=0.
REQ-032 par_ready=0, send 0x12 plus 7 bits of 0xFF -> ser_ready low, 8th bit dropped and overrun=1; par_ready=1 -> 0x12 strobed, ser_ready high the next cycle.
REQ-033 Downstream one-level buffer model with its full flag one cycle late and 3 words sent continuously -> no strobe during full, no word lost or duplicated.
REQ-034 3 bits, then frame_reset, then 0xFF -> par_data=0xFF and overrun cleared; a word pending during frame_reset is still strobed unchanged.
REQ-035 reset after 5 bits, then 0x81 -> all outputs at reset values during reset, then par_data=0x81 with one pulse.

Source files
------------

// File: rtl/deserializer.sv
// -----------------------------------------------------------------------------
// deserializer
//
// Assembles a serial bit stream into WIDTH-bit parallel words, MSB first.
// A completed word moves into a holding register (par_data) and is marked
// pending. It is then handed downstream as a one-cycle par_strobe pulse once
// the downstream side reports room (par_ready).
//
// If a word is still pending when the next word's last bit arrives, that bit
// is refused (ser_ready low). A refused bit that is offered anyway is dropped
// and recorded in the sticky overrun flag.
//
// Ports
//   clk          clock
//   reset        asynchronous, active-high reset
//   ser_data     serial bit value, sampled when ser_strobe is high
//   ser_strobe   level-valid: each cycle it is high offers one bit
//   ser_ready    combinational: a bit offered this cycle is accepted
//   frame_reset  synchronous resync: discards the partial word and overrun,
//                keeps any pending word
//   par_data     holding register with the last completed word
//   par_ready    downstream can take a word (the !full of a one-level buffer)
//   par_strobe   registered one-cycle pulse: par_data is valid for capture
//   overrun      sticky: a bit was dropped since the last reset/frame_reset
//   is_empty     registered: no partial bits and no pending word
// -----------------------------------------------------------------------------
module deserializer #(
    parameter int WIDTH       = 8,
    parameter int COUNT_WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ser_data,
    input  logic             ser_strobe,
    output logic             ser_ready,
    input  logic             frame_reset,
    output logic [WIDTH-1:0] par_data,
    input  logic             par_ready,
    output logic             par_strobe,
    output logic             overrun,
    output logic             is_empty
);

    localparam logic [COUNT_WIDTH-1:0] LAST_BIT = COUNT_WIDTH'(WIDTH - 1);

    // Registered state
    logic [WIDTH-1:0]       shifter;
    logic [COUNT_WIDTH-1:0] bit_count;
    logic                   pending;

    // Next-state values
    logic [WIDTH-1:0]       shifter_next;
    logic [COUNT_WIDTH-1:0] bit_count_next;
    logic                   pending_next;
    logic [WIDTH-1:0]       par_data_next;
    logic                   par_strobe_next;
    logic                   overrun_next;
    logic                   is_empty_next;

    // Per-cycle events
    logic accept;     // a bit is taken into the shifter
    logic drop;       // a bit is offered but refused
    logic word_done;  // the accepted bit completes a word
    logic issue;      // the pending word is strobed out at this edge

    // NOTE: every signal written here gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        shifter_next    = shifter;
        bit_count_next  = bit_count;
        pending_next    = pending;
        par_data_next   = par_data;
        overrun_next    = overrun;

        // The only moment a bit cannot be taken is when it would complete a
        // word while the previous word still sits in the holding register.
        ser_ready = !(pending && (bit_count == LAST_BIT));

        accept    = ser_strobe && ser_ready && !frame_reset;
        drop      = ser_strobe && !ser_ready && !frame_reset;
        word_done = accept && (bit_count == LAST_BIT);

        // par_ready is not looked at during a strobe cycle. This guarantees
        // at least one low cycle between pulses, so the downstream full
        // flag has time to update.
        issue = pending && par_ready && !par_strobe;

        if (issue) begin
            pending_next = 1'b0;
        end

        if (frame_reset) begin
            // Resync: the partial word and the overrun history go away. A
            // pending word and its strobe are left alone.
            shifter_next   = '0;
            bit_count_next = '0;
            overrun_next   = 1'b0;
        end else begin
            if (accept) begin
                shifter_next   = {shifter[WIDTH-2:0], ser_data};
                bit_count_next = (bit_count == LAST_BIT) ? '0
                               : bit_count + COUNT_WIDTH'(1);
            end
            // Loading a new word overrides the clear from issue above. The
            // new word then becomes the pending one.
            if (word_done) begin
                par_data_next = {shifter[WIDTH-2:0], ser_data};
                pending_next  = 1'b1;
            end
            if (drop) begin
                overrun_next = 1'b1;
            end
        end

        par_strobe_next = issue;
        is_empty_next   = (bit_count_next == '0) && !pending_next;
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, whatever order the statements are in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shifter    <= '0;
            bit_count  <= '0;
            pending    <= 1'b0;
            par_data   <= '0;
            par_strobe <= 1'b0;
            overrun    <= 1'b0;
            is_empty   <= 1'b1;
        end else begin
            shifter    <= shifter_next;
            bit_count  <= bit_count_next;
            pending    <= pending_next;
            par_data   <= par_data_next;
            par_strobe <= par_strobe_next;
            overrun    <= overrun_next;
            is_empty   <= is_empty_next;
        end
    end

endmodule

// File: tb/tb_deserializer.sv
// -----------------------------------------------------------------------------
// tb_deserializer
//
// Directed testbench for deserializer. Expected values are worked out by hand
// from the bit patterns sent.
//
// Inputs change #1 after a rising edge. Registered outputs are checked at
// that same point, so each check sees the state left by that edge.
// -----------------------------------------------------------------------------
module tb_deserializer;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             ser_data;
    logic             ser_strobe;
    logic             ser_ready;
    logic             frame_reset;
    logic [WIDTH-1:0] par_data;
    logic             par_ready;
    logic             par_strobe;
    logic             overrun;
    logic             is_empty;

    // par_ready comes either straight from the stimulus or from the
    // downstream buffer model.
    logic par_ready_drv = 1'b0;
    logic model_en      = 1'b0;
    logic buf_full      = 1'b0;
    assign par_ready = model_en ? !buf_full : par_ready_drv;

    deserializer #(.WIDTH(WIDTH), .COUNT_WIDTH(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .ser_data   (ser_data),
        .ser_strobe (ser_strobe),
        .ser_ready  (ser_ready),
        .frame_reset(frame_reset),
        .par_data   (par_data),
        .par_ready  (par_ready),
        .par_strobe (par_strobe),
        .overrun    (overrun),
        .is_empty   (is_empty)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Send the top n bits of w, MSB first, with ser_strobe held high.
    task automatic send_bits(input logic [7:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            ser_strobe = 1'b1;
            ser_data   = w[7-i];
            tick();
        end
        ser_strobe = 1'b0;
        ser_data   = 1'b0;
    endtask

    // Monitor: record every strobe, the cycles where ser_ready is low, and
    // any strobe that lands while the model buffer is full.
    int         cyc         = 0;
    int         ready_low   = 0;
    int         strobe_full = 0;
    logic [7:0] words[$];
    int         strobe_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (par_strobe === 1'b1) begin
            words.push_back(par_data);
            strobe_cyc.push_back(cyc);
            if (model_en && buf_full) strobe_full++;
        end
        if (ser_ready !== 1'b1) ready_low++;
    end

    // Downstream one-level buffer. It captures on the edge that ends the
    // strobe cycle, so its full flag rises one cycle late. It then holds the
    // word for 10 cycles before draining it.
    logic [7:0] buf_words[$];
    int         hold = 0;

    always @(posedge clk) begin
        if (!model_en) begin
            buf_full <= 1'b0;
            hold     <= 0;
        end else if (buf_full) begin
            if (hold == 9) begin
                buf_full <= 1'b0;
                hold     <= 0;
            end else begin
                hold <= hold + 1;
            end
        end else if (par_strobe) begin
            buf_full <= 1'b1;
            buf_words.push_back(par_data);
        end
    end

    initial begin
        reset       = 1'b1;
        ser_data    = 1'b0;
        ser_strobe  = 1'b0;
        frame_reset = 1'b0;

        // ---------------- reset values ----------------
        tick();
        tick();
        check("rst par_data",   par_data,   0);
        check("rst par_strobe", par_strobe, 0);
        check("rst overrun",    overrun,    0);
        check("rst is_empty",   is_empty,   1);
        check("rst ser_ready",  ser_ready,  1);
        reset = 1'b0;
        tick();

        // ---------------- 0xA5, single word ----------------
        par_ready_drv = 1'b1;
        words.delete();
        send_bits(8'hA5, 1);
        check("a5 is_empty after 1 bit", is_empty, 0);
        send_bits(8'h4A, 7);                        // remaining bits 0100101
        check("a5 no strobe at load",    par_strobe, 0);
        check("a5 not empty (pending)",  is_empty,   0);
        tick();
        check("a5 strobe",               par_strobe, 1);
        check("a5 par_data",             par_data,   8'hA5);
        tick();
        check("a5 strobe one cycle",     par_strobe, 0);
        check("a5 is_empty after",       is_empty,   1);
        check("a5 pulse count",          words.size(), 1);

        // ---------------- 0x3C then 0xC3, back to back ----------------
        words.delete();
        strobe_cyc.delete();
        ready_low = 0;
        send_bits(8'h3C, 8);
        send_bits(8'hC3, 8);
        tick();
        tick();
        tick();
        check("b2b pulse count", words.size(), 2);
        if (words.size() == 2) begin
            check("b2b word0", words[0], 8'h3C);
            check("b2b word1", words[1], 8'hC3);
            check("b2b spacing", strobe_cyc[1] - strobe_cyc[0], 8);
        end
        check("b2b ser_ready never low", ready_low, 0);
        check("b2b overrun", overrun, 0);

        // ---------------- backpressure and overrun ----------------
        words.delete();
        par_ready_drv = 1'b0;
        send_bits(8'h12, 8);
        send_bits(8'hFF, 7);
        check("ovr ser_ready low", ser_ready, 0);
        check("ovr overrun clear before drop", overrun, 0);
        ser_strobe = 1'b1;
        ser_data   = 1'b1;
        tick();
        ser_strobe = 1'b0;
        check("ovr overrun set", overrun, 1);
        check("ovr ser_ready still low", ser_ready, 0);
        check("ovr no strobe while blocked", words.size(), 0);
        par_ready_drv = 1'b1;
        tick();
        check("ovr strobe", par_strobe, 1);
        check("ovr par_data", par_data, 8'h12);
        check("ovr ser_ready high", ser_ready, 1);
        check("ovr overrun sticky", overrun, 1);
        tick();
        frame_reset = 1'b1;
        tick();
        frame_reset = 1'b0;
        check("ovr frame_reset clears overrun", overrun, 0);
        check("ovr frame_reset empties", is_empty, 1);

        // ---------------- downstream buffer model, 3 words ----------------
        words.delete();
        buf_words.delete();
        strobe_full = 0;
        model_en    = 1'b1;
        send_bits(8'h5A, 8);
        send_bits(8'h0F, 8);
        send_bits(8'hE7, 8);
        for (int i = 0; i < 20; i++) tick();
        check("buf words captured", buf_words.size(), 3);
        if (buf_words.size() == 3) begin
            check("buf word0", buf_words[0], 8'h5A);
            check("buf word1", buf_words[1], 8'h0F);
            check("buf word2", buf_words[2], 8'hE7);
        end
        check("buf strobe count", words.size(), 3);
        check("buf no strobe while full", strobe_full, 0);
        check("buf overrun", overrun, 0);
        model_en = 1'b0;
        tick();

        // ---------------- frame_reset mid-word ----------------
        words.delete();
        par_ready_drv = 1'b1;
        send_bits(8'hA0, 3);                        // 1,0,1 partial
        frame_reset = 1'b1;
        ser_strobe  = 1'b1;                         // discarded
        ser_data    = 1'b0;
        tick();
        frame_reset = 1'b0;
        ser_strobe  = 1'b0;
        check("frs partial discarded", is_empty, 1);
        send_bits(8'hFF, 8);
        tick();
        check("frs strobe", par_strobe, 1);
        check("frs par_data", par_data, 8'hFF);
        check("frs overrun", overrun, 0);
        tick();

        // frame_reset while a word is pending: that word is still strobed
        par_ready_drv = 1'b0;
        send_bits(8'h96, 8);
        send_bits(8'hC0, 2);
        frame_reset   = 1'b1;
        par_ready_drv = 1'b1;
        ser_strobe    = 1'b1;
        ser_data      = 1'b1;
        tick();
        frame_reset = 1'b0;
        ser_strobe  = 1'b0;
        check("frs pending strobe", par_strobe, 1);
        check("frs pending par_data", par_data, 8'h96);
        check("frs pending is_empty", is_empty, 1);
        tick();

        // ---------------- reset mid-word ----------------
        send_bits(8'hF8, 5);
        #2 reset = 1'b1;
        #1;
        check("mid rst par_data",   par_data,   0);
        check("mid rst par_strobe", par_strobe, 0);
        check("mid rst overrun",    overrun,    0);
        check("mid rst is_empty",   is_empty,   1);
        check("mid rst ser_ready",  ser_ready,  1);
        ser_strobe = 1'b1;
        ser_data   = 1'b1;
        tick();
        ser_strobe = 1'b0;
        check("mid rst held is_empty", is_empty, 1);
        reset = 1'b0;
        words.delete();
        send_bits(8'h81, 8);
        tick();
        tick();
        check("post rst par_data", par_data, 8'h81);
        check("post rst pulse count", words.size(), 1);
        if (words.size() == 1) check("post rst word", words[0], 8'h81);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
